// File: rtl/axis_video_pkg.sv
// Shared types and constants for the AXI4-Stream video geometry monitor.
package axis_video_pkg;

    // Default width of pixel/line counters and geometry outputs
    localparam int DIM_WIDTH_DEFAULT = 16;

    // Frame tracking state: idle until the first start-of-frame, then counting
    typedef enum logic [0:0] {
        WAIT_SOF = 1'b0,
        IN_FRAME = 1'b1
    } vid_state_e;

    // Bit positions inside the sticky error vector
    localparam int ERR_EOL_EARLY = 0;
    localparam int ERR_EOL_LATE  = 1;
    localparam int ERR_SOF_EARLY = 2;
    localparam int ERR_NUM       = 3;

endpackage

// File: rtl/video_geom_lock.sv
// Geometry lock tracker: counts consecutive identical good frames and
// publishes the locked width/height once enough of them have been seen.
module video_geom_lock
    import axis_video_pkg::*;
#(
    parameter int DIM_WIDTH   = DIM_WIDTH_DEFAULT,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_end_i,
    input  logic [DIM_WIDTH-1:0] frame_w_i,
    input  logic [DIM_WIDTH-1:0] frame_h_i,
    input  logic                 frame_bad_i,
    output logic [DIM_WIDTH-1:0] video_width_o,
    output logic [DIM_WIDTH-1:0] video_height_o,
    output logic                 video_size_valid_o
);

    localparam int MW = $clog2(LOCK_FRAMES + 1);
    localparam logic [MW-1:0] MATCH_MAX  = MW'(LOCK_FRAMES);
    localparam logic [MW-1:0] MATCH_ONE  = MW'(1);
    localparam logic [MW-1:0] MATCH_ZERO = MW'(0);

    logic [DIM_WIDTH-1:0] cand_w_q, cand_w_d;
    logic [DIM_WIDTH-1:0] cand_h_q, cand_h_d;
    logic [MW-1:0]        match_q, match_d;
    logic [DIM_WIDTH-1:0] width_q, width_d;
    logic [DIM_WIDTH-1:0] height_q, height_d;
    logic                 valid_q, valid_d;

    // Next-state: bad frames break the run, good frames extend or restart it
    always_comb begin
        cand_w_d = cand_w_q;
        cand_h_d = cand_h_q;
        match_d  = match_q;
        width_d  = width_q;
        height_d = height_q;
        valid_d  = valid_q;
        if (frame_end_i) begin
            if (frame_bad_i) begin
                match_d = MATCH_ZERO;
                valid_d = 1'b0;
            end else begin
                if ((match_q != MATCH_ZERO) && (frame_w_i == cand_w_q) && (frame_h_i == cand_h_q)) begin
                    match_d = (match_q == MATCH_MAX) ? MATCH_MAX : match_q + MATCH_ONE;
                end else begin
                    cand_w_d = frame_w_i;
                    cand_h_d = frame_h_i;
                    match_d  = MATCH_ONE;
                end
                if (match_d == MATCH_MAX) begin
                    width_d  = frame_w_i;
                    height_d = frame_h_i;
                    valid_d  = 1'b1;
                end else begin
                    valid_d  = 1'b0;
                end
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Lock state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand_w_q <= '0;
            cand_h_q <= '0;
            match_q  <= MATCH_ZERO;
            width_q  <= '0;
            height_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            cand_w_q <= cand_w_d;
            cand_h_q <= cand_h_d;
            match_q  <= match_d;
            width_q  <= width_d;
            height_q <= height_d;
            valid_q  <= valid_d;
        end
    end

    assign video_width_o      = width_q;
    assign video_height_o     = height_q;
    assign video_size_valid_o = valid_q;

endmodule

// File: rtl/axis_video_geometry_monitor.sv
// Inline AXI4-Stream video monitor: combinational passthrough, frame
// geometry measurement, malformed line/frame detection and geometry lock.
module axis_video_geometry_monitor
    import axis_video_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int DIM_WIDTH       = DIM_WIDTH_DEFAULT,
    parameter int LOCK_FRAMES     = 2,
    parameter int FRAME_CNT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]    s_axis_tkeep,
    input  logic                       s_axis_tlast,
    input  logic                       s_axis_tuser,
    output logic                       m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]    m_axis_tkeep,
    output logic                       m_axis_tlast,
    output logic                       m_axis_tuser,
    input  logic                       m_axis_tready,
    output logic [DIM_WIDTH-1:0]       video_width,
    output logic [DIM_WIDTH-1:0]       video_height,
    output logic                       video_size_valid,
    output logic                       frame_done,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count,
    output logic                       err_eol_early,
    output logic                       err_eol_late,
    output logic                       err_sof_early,
    input  logic                       err_clear
);

    localparam logic [DIM_WIDTH-1:0] DIM_MAX  = {DIM_WIDTH{1'b1}};
    localparam logic [DIM_WIDTH-1:0] DIM_ONE  = {{(DIM_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DIM_WIDTH-1:0] DIM_ZERO = {DIM_WIDTH{1'b0}};
    localparam logic [FRAME_CNT_WIDTH-1:0] FC_ONE = {{(FRAME_CNT_WIDTH-1){1'b0}}, 1'b1};

    vid_state_e           state_q, state_d;
    logic [DIM_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
    logic [DIM_WIDTH-1:0] line_cnt_q, line_cnt_d;
    logic [DIM_WIDTH-1:0] frame_w_q, frame_w_d;
    logic                 frame_bad_q, frame_bad_d;
    logic [ERR_NUM-1:0]   err_q;
    logic [ERR_NUM-1:0]   err_new_s;
    logic                 frame_done_q;
    logic [FRAME_CNT_WIDTH-1:0] frame_count_q;
    logic                 beat_s;
    logic                 frame_end_s;
    logic                 frame_end_bad_s;
    logic [DIM_WIDTH-1:0] pix_inc_s;
    logic [DIM_WIDTH-1:0] line_inc_s;
    logic                 pix_sat_s;
    logic                 line_sat_s;

    // The stream is never touched: ready and payload are wired straight through
    assign s_axis_tready = m_axis_tready;
    assign m_axis_tvalid = s_axis_tvalid;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tkeep  = s_axis_tkeep;
    assign m_axis_tlast  = s_axis_tlast;
    assign m_axis_tuser  = s_axis_tuser;

    assign beat_s     = s_axis_tvalid & m_axis_tready;
    assign pix_sat_s  = (pix_cnt_q == DIM_MAX);
    assign line_sat_s = (line_cnt_q == DIM_MAX);
    assign pix_inc_s  = pix_sat_s ? DIM_MAX : pix_cnt_q + DIM_ONE;
    assign line_inc_s = line_sat_s ? DIM_MAX : line_cnt_q + DIM_ONE;

    // Beat decoding: frame tracking, line measurement and error detection
    always_comb begin
        state_d         = state_q;
        pix_cnt_d       = pix_cnt_q;
        line_cnt_d      = line_cnt_q;
        frame_w_d       = frame_w_q;
        frame_bad_d     = frame_bad_q;
        err_new_s       = '0;
        frame_end_s     = 1'b0;
        frame_end_bad_s = 1'b0;
        if (beat_s && s_axis_tuser) begin
            // An SOF beat closes any open frame and is pixel 1 of the next one
            if (state_q == IN_FRAME) begin
                frame_end_s = 1'b1;
                if ((pix_cnt_q != DIM_ZERO) ||
                    (video_size_valid && (line_cnt_q != video_height))) begin
                    err_new_s[ERR_SOF_EARLY] = 1'b1;
                end else begin
                    err_new_s[ERR_SOF_EARLY] = 1'b0;
                end
                frame_end_bad_s = frame_bad_q | err_new_s[ERR_SOF_EARLY];
            end else begin
                frame_end_s = 1'b0;
            end
            state_d     = IN_FRAME;
            frame_bad_d = 1'b0;
            if (s_axis_tlast) begin
                frame_w_d  = DIM_ONE;
                line_cnt_d = DIM_ONE;
                pix_cnt_d  = DIM_ZERO;
            end else begin
                line_cnt_d = DIM_ZERO;
                pix_cnt_d  = DIM_ONE;
            end
        end else if (beat_s && (state_q == IN_FRAME)) begin
            err_new_s[ERR_EOL_LATE] = pix_sat_s;
            if (s_axis_tlast) begin
                if (line_cnt_q == DIM_ZERO) begin
                    frame_w_d = pix_inc_s;
                end else if (pix_inc_s < frame_w_q) begin
                    err_new_s[ERR_EOL_EARLY] = 1'b1;
                end else if (pix_inc_s > frame_w_q) begin
                    err_new_s[ERR_EOL_LATE] = 1'b1;
                end else begin
                    frame_w_d = frame_w_q;
                end
                if (line_sat_s) begin
                    err_new_s[ERR_EOL_LATE] = 1'b1;
                end else begin
                    line_cnt_d = line_inc_s;
                end
                pix_cnt_d = DIM_ZERO;
            end else begin
                pix_cnt_d = pix_inc_s;
            end
            frame_bad_d = frame_bad_q | (|err_new_s);
        end else begin
            state_d = state_q;
        end
    end

    // Frame tracking registers, sticky errors and frame statistics
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= WAIT_SOF;
            pix_cnt_q     <= DIM_ZERO;
            line_cnt_q    <= DIM_ZERO;
            frame_w_q     <= DIM_ZERO;
            frame_bad_q   <= 1'b0;
            err_q         <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            frame_w_q     <= frame_w_d;
            frame_bad_q   <= frame_bad_d;
            // A new error in the clearing cycle survives the clear
            err_q         <= (err_q & ~{ERR_NUM{err_clear}}) | err_new_s;
            frame_done_q  <= frame_end_s;
            frame_count_q <= frame_end_s ? frame_count_q + FC_ONE : frame_count_q;
        end
    end

    video_geom_lock #(
        .DIM_WIDTH   (DIM_WIDTH),
        .LOCK_FRAMES (LOCK_FRAMES)
    ) u_lock (
        .clk                (clk),
        .reset              (reset),
        .frame_end_i        (frame_end_s),
        .frame_w_i          (frame_w_q),
        .frame_h_i          (line_cnt_q),
        .frame_bad_i        (frame_end_bad_s),
        .video_width_o      (video_width),
        .video_height_o     (video_height),
        .video_size_valid_o (video_size_valid)
    );

    assign frame_done    = frame_done_q;
    assign frame_count   = frame_count_q;
    assign err_eol_early = err_q[ERR_EOL_EARLY];
    assign err_eol_late  = err_q[ERR_EOL_LATE];
    assign err_sof_early = err_q[ERR_SOF_EARLY];

endmodule

// File: tb/tb_axis_video_geometry_monitor.sv
// Self-checking bench: frames described as line-length lists, judged by a
// frame-level reference model of geometry, errors and lock.
module tb_axis_video_geometry_monitor;

    localparam int DW   = 32;
    localparam int KW   = DW / 8;
    localparam int DIMW = 16;
    localparam int LOCK = 2;
    localparam int FCW  = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            s_axis_tvalid;
    logic            s_axis_tready;
    logic [DW-1:0]   s_axis_tdata;
    logic [KW-1:0]   s_axis_tkeep;
    logic            s_axis_tlast;
    logic            s_axis_tuser;
    logic            m_axis_tvalid;
    logic [DW-1:0]   m_axis_tdata;
    logic [KW-1:0]   m_axis_tkeep;
    logic            m_axis_tlast;
    logic            m_axis_tuser;
    logic            m_axis_tready;
    logic [DIMW-1:0] video_width;
    logic [DIMW-1:0] video_height;
    logic            video_size_valid;
    logic            frame_done;
    logic [FCW-1:0]  frame_count;
    logic            err_eol_early;
    logic            err_eol_late;
    logic            err_sof_early;
    logic            err_clear;

    axis_video_geometry_monitor #(
        .DATA_WIDTH (DW), .DIM_WIDTH (DIMW), .LOCK_FRAMES (LOCK), .FRAME_CNT_WIDTH (FCW)
    ) dut (
        .clk (clk), .reset (reset),
        .s_axis_tvalid (s_axis_tvalid), .s_axis_tready (s_axis_tready),
        .s_axis_tdata (s_axis_tdata), .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tlast (s_axis_tlast), .s_axis_tuser (s_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid), .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep), .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser), .m_axis_tready (m_axis_tready),
        .video_width (video_width), .video_height (video_height),
        .video_size_valid (video_size_valid), .frame_done (frame_done),
        .frame_count (frame_count), .err_eol_early (err_eol_early),
        .err_eol_late (err_eol_late), .err_sof_early (err_sof_early),
        .err_clear (err_clear)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int       exp_count, exp_w, exp_h, cand_w, cand_h, match;
    bit       exp_valid;
    bit [2:0] exp_err;          // {sof_early, eol_late, eol_early}
    int       done_pulses;
    bit       pend_valid, pend_early, pend_late, pend_part, pend_clr;
    int       pend_w, pend_h;
    bit       rand_mode;
    int       line_q[$];
    event     frame_end_ev;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_count = 0; exp_w = 0; exp_h = 0; cand_w = 0; cand_h = 0; match = 0;
        exp_valid = 1'b0; exp_err = 3'b000; pend_valid = 1'b0;
    endtask

    // Judge the frame that the current SOF beat has just closed
    task automatic end_pending();
        bit sof, bad;
        if (pend_valid) begin
            sof = pend_part || (exp_valid && (pend_h != exp_h));
            bad = pend_early || pend_late || sof;
            if (pend_clr) exp_err = 3'b000;
            exp_err = exp_err | {sof, pend_late, pend_early};
            if (bad) begin
                match = 0;
                exp_valid = 1'b0;
            end else begin
                if (match > 0 && pend_w == cand_w && pend_h == cand_h) begin
                    if (match < LOCK) match++;
                end else begin
                    cand_w = pend_w; cand_h = pend_h; match = 1;
                end
                if (match >= LOCK) begin
                    exp_valid = 1'b1; exp_w = pend_w; exp_h = pend_h;
                end else begin
                    exp_valid = 1'b0;
                end
            end
            exp_count++;
            ->frame_end_ev;
        end
    endtask

    task automatic send_beat(input logic user, input logic last, input logic clr);
        int  gaps;
        bit  acc;
        gaps = rand_mode ? int'($urandom_range(0, 2)) : 0;
        for (int g = 0; g < gaps; g++) begin
            s_axis_tvalid = 1'b0;
            s_axis_tuser  = 1'($urandom);
            s_axis_tlast  = 1'($urandom);
            s_axis_tdata  = $urandom;
            m_axis_tready = 1'($urandom);
            @(posedge clk); #1;
        end
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = $urandom;
        s_axis_tkeep  = KW'($urandom);
        s_axis_tuser  = user;
        s_axis_tlast  = last;
        err_clear     = clr;
        acc = 1'b0;
        for (int t = 0; t < 6 && !acc; t++) begin
            m_axis_tready = (!rand_mode || t == 5) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
            @(posedge clk);
            acc = m_axis_tready;
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
        err_clear     = 1'b0;
    endtask

    // Send one frame made of the lines in line_q plus an unterminated tail
    task automatic run_frame(input int tail, input int clr_line);
        int w, h;
        bit early, late, first;
        h = line_q.size();
        w = (h > 0) ? line_q[0] : 0;
        early = 1'b0; late = 1'b0; first = 1'b1;
        for (int i = 1; i < h; i++) begin
            if (line_q[i] < w) early = 1'b1;
            if (line_q[i] > w) late = 1'b1;
        end
        for (int i = 0; i < h; i++) begin
            for (int p = 1; p <= line_q[i]; p++) begin
                send_beat(first, p == line_q[i], (i == clr_line) && (p == line_q[i]));
                if (first) begin end_pending(); first = 1'b0; end
            end
        end
        for (int p = 1; p <= tail; p++) begin
            send_beat(first, 1'b0, 1'b0);
            if (first) begin end_pending(); first = 1'b0; end
        end
        pend_valid = 1'b1; pend_w = w; pend_h = h;
        pend_early = early; pend_late = late;
        pend_part = (tail != 0); pend_clr = (clr_line >= 0);
    endtask

    task automatic send_frames(input int w, input int h, input int n);
        line_q.delete();
        for (int i = 0; i < h; i++) line_q.push_back(w);
        for (int k = 0; k < n; k++) run_frame(0, -1);
    endtask

    task automatic check_reset_state();
        check_val("rst_width", video_width, 64'd0);
        check_val("rst_height", video_height, 64'd0);
        check_val("rst_valid", video_size_valid, 64'd0);
        check_val("rst_done", frame_done, 64'd0);
        check_val("rst_count", frame_count, 64'd0);
        check_val("rst_errs", {err_sof_early, err_eol_late, err_eol_early}, 64'd0);
    endtask

    // Passthrough integrity and frame_done pulse counting, every cycle
    initial begin
        done_pulses = 0;
        forever begin
            @(negedge clk);
            check_val("passthru",
                {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, s_axis_tready},
                {s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser, m_axis_tready});
            if (reset) done_pulses = 0;
            else if (frame_done) done_pulses++;
        end
    end

    // Frame-end checks on the frame_done cycle
    initial begin
        forever begin
            @(frame_end_ev);
            @(negedge clk); #1;
            check_val("frame_done", frame_done, 64'd1);
            check_val("done_pulses", 64'(done_pulses), 64'(exp_count));
            check_val("frame_count", frame_count, 64'(exp_count));
            check_val("size_valid", video_size_valid, 64'(exp_valid));
            check_val("video_width", video_width, 64'(exp_w));
            check_val("video_height", video_height, 64'(exp_h));
            check_val("err_flags", {err_sof_early, err_eol_late, err_eol_early}, 64'(exp_err));
        end
    end

    initial begin
        reset = 1'b1; err_clear = 1'b0; rand_mode = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
        s_axis_tlast = 1'b0; s_axis_tuser = 1'b0; m_axis_tready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        reset = 1'b0;
        @(posedge clk); #1;

        // Back-to-back 4x3 frames lock on the third SOF
        send_frames(4, 3, 3);
        // Random gaps and backpressure on 640x4 frames
        rand_mode = 1'b1;
        send_frames(640, 4, 4);
        rand_mode = 1'b0;
        // Lock 8x3, then a short line with err_clear on that very beat
        send_frames(8, 3, 3);
        line_q = '{8, 8, 6};
        run_frame(0, 2);
        send_frames(8, 3, 1);
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        exp_err = 3'b000;
        @(negedge clk); #1;
        check_val("err_cleared", {err_sof_early, err_eol_late, err_eol_early}, 64'd0);
        // Relock, then SOF at pixel 3 of a line, then relock again
        rand_mode = 1'b1;
        send_frames(8, 3, 2);
        line_q = '{8, 8};
        run_frame(2, -1);
        send_frames(8, 3, 3);
        rand_mode = 1'b0;
        // Geometry change 4x3 -> 5x3
        send_frames(4, 3, 3);
        send_frames(5, 3, 3);
        // 1x1 frames of single SOF+EOL beats
        send_frames(1, 1, 4);
        // Reset in the middle of a frame
        send_beat(1'b1, 1'b0, 1'b0);
        end_pending();
        send_beat(1'b0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check_reset_state();
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        send_beat(1'b0, 1'b0, 1'b0);
        send_beat(1'b0, 1'b1, 1'b0);
        send_frames(1, 1, 4);
        repeat (4) @(posedge clk);
        #1;
        check_val("final_count", frame_count, 64'(exp_count));
        check_val("final_valid", video_size_valid, 64'(exp_valid));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
